// File: rtl/altera_tse_tbi_comma_align_pkg.sv
// Shared constants, state encoding and small helpers for the TBI receive word aligner.
package altera_tse_tbi_comma_align_pkg;

    // Seven-bit comma in bit-vector order (bit 0 is the first bit on the wire).
    localparam logic [6:0] COMMA_POS = 7'b1111100;
    localparam logic [6:0] COMMA_NEG = 7'b0000011;

    localparam logic [9:0] K28_5_NEG = 10'h17C;
    localparam logic [9:0] K28_5_POS = 10'h283;

    localparam int OFFSETS = 10;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ACQ     = 2'd1,
        ST_ALIGNED = 2'd2
    } align_state_e;

    function automatic logic is_comma(input logic [6:0] cand);
        return (cand == COMMA_POS) || (cand == COMMA_NEG);
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/altera_tse_tbi_comma_align_if.sv
// Raw SERDES word in, aligned code-group and alignment status out.
interface altera_tse_tbi_comma_align_if;
    logic [9:0] tbi_raw_d;
    logic       align_en;
    logic [9:0] tbi_rx_d;
    logic       rx_comma;
    logic       rx_aligned;
    logic [3:0] align_offset;
    logic       realign;

    modport master (
        output tbi_raw_d,
        output align_en,
        input  tbi_rx_d,
        input  rx_comma,
        input  rx_aligned,
        input  align_offset,
        input  realign
    );

    modport slave (
        input  tbi_raw_d,
        input  align_en,
        output tbi_rx_d,
        output rx_comma,
        output rx_aligned,
        output align_offset,
        output realign
    );
endinterface

// File: rtl/altera_tse_comma_detect.sv
// Combinational comma search over the ten bit offsets of the two-word window.
// Only window bits [15:0] can hold the seven comma bits of any offset 0..9.
module altera_tse_comma_detect
    import altera_tse_tbi_comma_align_pkg::*;
(
    input  logic [15:0] window_i,
    output logic        hit_o,
    output logic [3:0]  first_k_o,
    output logic [9:0]  hit_at_o
);

    logic [9:0] hits_s;

    // Scan from the top offset down so the lowest matching offset is written last.
    always_comb begin
        hits_s    = 10'd0;
        first_k_o = 4'd0;
        for (int k = OFFSETS - 1; k >= 0; k--) begin
            hits_s[k] = is_comma(window_i[k +: 7]);
            if (hits_s[k]) begin
                first_k_o = 4'(k);
            end else begin
                first_k_o = first_k_o;
            end
        end
        hit_o    = |hits_s;
        hit_at_o = hits_s;
    end

endmodule

// File: rtl/altera_tse_tbi_comma_align.sv
// TBI receive word aligner: two-stage pipeline, offset mux and HUNT/ACQ/ALIGNED lock FSM.
module altera_tse_tbi_comma_align
    import altera_tse_tbi_comma_align_pkg::*;
#(
    parameter int COMMA_CONFIRM = 3,
    parameter int MISALIGN_MAX  = 4
) (
    input  logic                         tbi_rx_clk,
    input  logic                         reset_rx_clk_n,
    altera_tse_tbi_comma_align_if.slave  rx_if
);

    localparam logic [3:0] CONFIRM_C = 4'(COMMA_CONFIRM);
    localparam logic [3:0] MIS_MAX_C = 4'(MISALIGN_MAX);

    logic [9:0]   cur_q, prev_q;
    logic [19:0]  window_s;
    logic         hit_s;
    logic [3:0]   first_k_s;
    logic [9:0]   hit_at_s;
    logic         hit_at_off_s;
    logic [3:0]   cnt_inc_s, mis_inc_s;

    align_state_e state_q, state_d;
    logic [3:0]   off_q, off_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   mis_q, mis_d;
    logic [9:0]   rxd_q, rxd_d;
    logic         comma_q, comma_d;
    logic         aligned_q, aligned_d;
    logic         realign_q, realign_d;

    assign window_s     = {cur_q, prev_q};
    assign hit_at_off_s = hit_at_s[off_q];
    assign cnt_inc_s    = sat_inc4(cnt_q);
    assign mis_inc_s    = sat_inc4(mis_q);

    altera_tse_comma_detect u_detect (
        .window_i  (window_s[15:0]),
        .hit_o     (hit_s),
        .first_k_o (first_k_s),
        .hit_at_o  (hit_at_s)
    );

    // Lock FSM; a hit at the current offset outranks any lower-offset hit.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        if (rx_if.align_en) begin
            case (state_q)
                ST_HUNT: begin
                    if (hit_s) begin
                        off_d = first_k_s;
                        cnt_d = 4'd1;
                        if (4'd1 >= CONFIRM_C) begin
                            state_d = ST_ALIGNED;
                            mis_d   = 4'd0;
                        end else begin
                            state_d = ST_ACQ;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_ACQ: begin
                    if (hit_at_off_s) begin
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s >= CONFIRM_C) begin
                            state_d = ST_ALIGNED;
                            mis_d   = 4'd0;
                        end else begin
                            state_d = ST_ACQ;
                        end
                    end else if (hit_s) begin
                        off_d = first_k_s;
                        cnt_d = 4'd1;
                    end else begin
                        state_d = ST_ACQ;
                    end
                end
                ST_ALIGNED: begin
                    if (hit_at_off_s) begin
                        mis_d = 4'd0;
                    end else if (hit_s) begin
                        mis_d = mis_inc_s;
                        if (mis_inc_s >= MIS_MAX_C) begin
                            state_d = ST_HUNT;
                            cnt_d   = 4'd0;
                            mis_d   = 4'd0;
                        end else begin
                            state_d = ST_ALIGNED;
                        end
                    end else begin
                        state_d = ST_ALIGNED;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    cnt_d   = 4'd0;
                    mis_d   = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output stage uses the offset in effect this cycle, so a new lock is aligned immediately.
    always_comb begin
        rxd_d     = 10'(window_s >> off_d);
        comma_d   = hit_at_s[off_d];
        aligned_d = (state_d == ST_ALIGNED);
        realign_d = (off_d != off_q);
    end

    // Input pipeline: newest word in cur, previous word in prev.
    always_ff @(posedge tbi_rx_clk or negedge reset_rx_clk_n) begin
        if (!reset_rx_clk_n) begin
            cur_q  <= 10'd0;
            prev_q <= 10'd0;
        end else begin
            cur_q  <= rx_if.tbi_raw_d;
            prev_q <= cur_q;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge tbi_rx_clk or negedge reset_rx_clk_n) begin
        if (!reset_rx_clk_n) begin
            state_q   <= ST_HUNT;
            off_q     <= 4'd0;
            cnt_q     <= 4'd0;
            mis_q     <= 4'd0;
            rxd_q     <= 10'd0;
            comma_q   <= 1'b0;
            aligned_q <= 1'b0;
            realign_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            mis_q     <= mis_d;
            rxd_q     <= rxd_d;
            comma_q   <= comma_d;
            aligned_q <= aligned_d;
            realign_q <= realign_d;
        end
    end

    assign rx_if.tbi_rx_d     = rxd_q;
    assign rx_if.rx_comma     = comma_q;
    assign rx_if.rx_aligned   = aligned_q;
    assign rx_if.align_offset = off_q;
    assign rx_if.realign      = realign_q;

endmodule

// File: tb/tb_altera_tse_tbi_comma_align.sv
// Bench for the TBI word aligner: bit-level stream builder, reference model and directed/random phases.
module tb_altera_tse_tbi_comma_align;
    import altera_tse_tbi_comma_align_pkg::*;

    localparam int CONFIRM = 3;
    localparam int MIS_MAX = 4;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rst_lvl = 1'b0;

    altera_tse_tbi_comma_align_if rx_if ();

    altera_tse_tbi_comma_align #(
        .COMMA_CONFIRM (CONFIRM),
        .MISALIGN_MAX  (MIS_MAX)
    ) dut (
        .tbi_rx_clk     (clk),
        .reset_rx_clk_n (rst_n),
        .rx_if          (rx_if.slave)
    );

    always #4 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Wire-order bit queue; K28.5 (both disparities) interleaved with D16.2.
    bit         bq[$];
    int         pi = 0;
    logic [9:0] pat[4] = '{K28_5_NEG, 10'h289, K28_5_POS, 10'h2B6};

    logic [9:0]  m_cur, m_prev;
    int          m_st, m_off, m_cnt, m_mis;
    logic [16:0] m_exp;

    int realign_cnt, comma_cnt, commas_at_align;
    bit aligned_seen, dropped, chk_val;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] dut_out();
        return {rx_if.tbi_rx_d, rx_if.rx_comma, rx_if.rx_aligned, rx_if.align_offset, rx_if.realign};
    endfunction

    // Comma as a 7-bit wire sequence starting at window bit k: 0011111 or 1100000.
    function automatic bit comma_at(input logic [19:0] w, input int k);
        bit pos;
        bit neg;
        pos = 1'b1;
        neg = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (w[k + i] !== (i >= 2)) pos = 1'b0;
            if (w[k + i] !== (i < 2))  neg = 1'b0;
        end
        return pos | neg;
    endfunction

    task automatic model_reset();
        m_cur = 10'd0; m_prev = 10'd0;
        m_st = 0; m_off = 0; m_cnt = 0; m_mis = 0;
        m_exp = 17'd0;
    endtask

    task automatic model_step(input logic [9:0] raw, input logic en);
        logic [19:0] w;
        bit          hits[10];
        bit          any;
        int          first, noff, nst;
        w = {m_cur, m_prev};
        any = 1'b0;
        first = 0;
        for (int k = 9; k >= 0; k--) begin
            hits[k] = comma_at(w, k);
            if (hits[k]) begin any = 1'b1; first = k; end
        end
        noff = m_off;
        nst  = m_st;
        if (en) begin
            if (m_st == 0) begin
                if (any) begin
                    noff = first; m_cnt = 1;
                    if (m_cnt >= CONFIRM) begin nst = 2; m_mis = 0; end
                    else nst = 1;
                end
            end else if (m_st == 1) begin
                if (hits[m_off]) begin
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                    if (m_cnt >= CONFIRM) begin nst = 2; m_mis = 0; end
                end else if (any) begin
                    noff = first; m_cnt = 1;
                end
            end else begin
                if (hits[m_off]) m_mis = 0;
                else if (any) begin
                    m_mis = (m_mis < 15) ? m_mis + 1 : 15;
                    if (m_mis >= MIS_MAX) begin nst = 0; m_cnt = 0; m_mis = 0; end
                end
            end
        end
        m_exp = {10'(w >> noff), hits[noff], (nst == 2), 4'(noff), (noff != m_off)};
        m_off = noff;
        m_st  = nst;
        m_prev = m_cur;
        m_cur  = raw;
    endtask

    task automatic clear_obs();
        realign_cnt = 0;
        comma_cnt = 0;
        commas_at_align = 0;
        aligned_seen = rx_if.rx_aligned;
        dropped = 1'b0;
    endtask

    task automatic tick(input logic [9:0] raw, input logic en);
        @(negedge clk);
        rx_if.tbi_raw_d = raw;
        rx_if.align_en  = en;
        rst_n = rst_lvl;
        if (!rst_lvl) begin
            #1;
            check_eq("rst_outputs", 32'(dut_out()), 32'd0);
        end
        @(posedge clk);
        if (!rst_lvl) model_reset();
        else model_step(raw, en);
        #1;
        check_eq("cycle", 32'(dut_out()), 32'(m_exp));
        if (rx_if.realign) realign_cnt++;
        if (rx_if.rx_comma) comma_cnt++;
        if (!rx_if.rx_aligned) begin
            dropped = 1'b1;
            aligned_seen = 1'b0;
        end else if (!aligned_seen) begin
            aligned_seen = 1'b1;
            commas_at_align = comma_cnt;
        end
        if (chk_val && rx_if.rx_comma)
            check_eq("comma_word",
                     32'((rx_if.tbi_rx_d == K28_5_NEG) || (rx_if.tbi_rx_d == K28_5_POS)), 32'd1);
    endtask

    task automatic push_bits(input int n, input bit rnd);
        for (int i = 0; i < n; i++) bq.push_back(rnd ? bit'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic run_chars(input int n, input logic en);
        logic [9:0] v;
        logic [9:0] raw;
        for (int i = 0; i < n; i++) begin
            v = pat[pi];
            pi = (pi + 1) % 4;
            for (int b = 0; b < 10; b++) bq.push_back(v[b]);
            while (bq.size() >= 10) begin
                for (int b = 0; b < 10; b++) raw[b] = bq.pop_front();
                tick(raw, en);
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_lvl = 1'b0;
        repeat (n) tick(10'd0, 1'b1);
        rst_lvl = 1'b1;
        bq.delete();
        pi = 0;
    endtask

    initial begin
        int guard;
        rx_if.tbi_raw_d = 10'd0;
        rx_if.align_en  = 1'b1;
        chk_val = 1'b1;
        model_reset();
        clear_obs();

        // Reset, then idle input keeps HUNT.
        do_reset(3);
        repeat (6) tick(10'd0, 1'b1);
        check_eq("idle_aligned", 32'(rx_if.rx_aligned), 32'd0);
        check_eq("idle_offset", 32'(rx_if.align_offset), 32'd0);

        // Lock on a stream shifted by 3 bits.
        clear_obs();
        push_bits(3, 1'b0);
        run_chars(8, 1'b1);
        check_eq("lock_offset", 32'(rx_if.align_offset), 32'd3);
        check_eq("lock_aligned", 32'(rx_if.rx_aligned), 32'd1);
        check_eq("lock_realign", 32'(realign_cnt), 32'd1);
        check_eq("lock_commas", 32'(commas_at_align), 32'(CONFIRM));

        // One-bit slip: drop after the misalign limit, relock at 4.
        clear_obs();
        push_bits(1, 1'b0);
        run_chars(20, 1'b1);
        check_eq("slip_dropped", 32'(dropped), 32'd1);
        check_eq("slip_offset", 32'(rx_if.align_offset), 32'd4);
        check_eq("slip_aligned", 32'(rx_if.rx_aligned), 32'd1);
        check_eq("slip_realign", 32'(realign_cnt), 32'd1);

        // Three stray commas then a good one: lock holds.
        clear_obs();
        push_bits(1, 1'b0);
        run_chars(5, 1'b1);
        push_bits(9, 1'b0);
        run_chars(6, 1'b1);
        check_eq("trans_dropped", 32'(dropped), 32'd0);
        check_eq("trans_offset", 32'(rx_if.align_offset), 32'd4);
        check_eq("trans_realign", 32'(realign_cnt), 32'd0);

        // Frozen while the stream shifts, then released.
        clear_obs();
        push_bits(1, 1'b0);
        run_chars(12, 1'b0);
        check_eq("frz_offset", 32'(rx_if.align_offset), 32'd4);
        check_eq("frz_dropped", 32'(dropped), 32'd0);
        check_eq("frz_realign", 32'(realign_cnt), 32'd0);
        clear_obs();
        run_chars(24, 1'b1);
        check_eq("unfrz_dropped", 32'(dropped), 32'd1);
        check_eq("unfrz_offset", 32'(rx_if.align_offset), 32'd5);
        check_eq("unfrz_aligned", 32'(rx_if.rx_aligned), 32'd1);
        check_eq("unfrz_realign", 32'(realign_cnt), 32'd1);

        // Reset in ACQ after two commas; three fresh commas needed afterwards.
        do_reset(2);
        clear_obs();
        push_bits(7, 1'b0);
        guard = 0;
        while (comma_cnt < 2 && guard < 20) begin
            run_chars(1, 1'b1);
            guard++;
        end
        check_eq("acq_commas", 32'(comma_cnt), 32'd2);
        check_eq("acq_not_aligned", 32'(rx_if.rx_aligned), 32'd0);
        do_reset(2);
        check_eq("rst_offset", 32'(rx_if.align_offset), 32'd0);
        clear_obs();
        push_bits(7, 1'b0);
        run_chars(10, 1'b1);
        check_eq("relock_commas", 32'(commas_at_align), 32'(CONFIRM));
        check_eq("relock_offset", 32'(rx_if.align_offset), 32'd7);

        // Random bursts checked cycle by cycle against the model.
        chk_val = 1'b0;
        for (int b = 0; b < 40; b++) begin
            case ($urandom_range(0, 3))
                0: begin
                    int n;
                    n = $urandom_range(4, 16);
                    for (int i = 0; i < n; i++)
                        tick(10'($urandom), logic'($urandom_range(0, 7) != 0));
                end
                1: begin
                    push_bits($urandom_range(0, 9), 1'b1);
                    run_chars($urandom_range(6, 20), logic'($urandom_range(0, 5) != 0));
                end
                2: begin
                    rst_lvl = 1'b0;
                    repeat ($urandom_range(1, 2)) tick(10'($urandom), 1'b1);
                    rst_lvl = 1'b1;
                end
                default: run_chars($urandom_range(10, 30), 1'b1);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
